// File: rtl/ula_pkg.sv
// Shared types and constants for the multi-cycle ALU: default width, opcodes,
// FSM states and the step-counter sizing helper.
package ula_pkg;

  localparam int ULA_WIDTH = 64;
  localparam int SHAMT_W   = 6;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLL  = 3'b101,
    OP_SRL  = 3'b110,
    OP_MUL  = 3'b111
  } ula_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } ula_estado_t;

  // The step counter must hold a shift amount minus one and WIDTH-1 multiply steps.
  function automatic int cnt_bits(input int width);
    return ($clog2(width) > SHAMT_W) ? $clog2(width) : SHAMT_W;
  endfunction

endpackage

// File: rtl/ula_multiciclo_if.sv
// Request/result bundle between the control unit (master) and the ALU (slave).
interface ula_multiciclo_if #(
  parameter int WIDTH = ula_pkg::ULA_WIDTH
);
  import ula_pkg::*;

  // Handshake: start is a request taken on a rising edge only while busy=0;
  // done pulses for exactly one cycle after each SAIDA update, and SAIDA with
  // its flags stays stable until the next completed operation.
  logic             start;
  ula_op_t          OP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] SAIDA;
  logic             ZERO;
  logic             IGUAL;
  logic             MENOR;
  logic             busy;
  logic             done;

  modport master (
    output start, OP, A, B,
    input  SAIDA, ZERO, IGUAL, MENOR, busy, done
  );

  modport slave (
    input  start, OP, A, B,
    output SAIDA, ZERO, IGUAL, MENOR, busy, done
  );

endinterface

// File: rtl/ula_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per 'step' cycle,
// 'result' is the low WIDTH bits of the product after the current step.
module ula_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  // Exposing the post-step sum lets the caller latch the product on the last step edge.
  assign result = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (step) begin
      acc    <= result;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, bit-serial shifts and, when
// ULA_MUL_EN is defined, an iterative WIDTH-step multiply.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  ula_multiciclo_if.slave     bus,
  output ula_estado_t         estado
);

  localparam int CW = cnt_bits(WIDTH);

  ula_estado_t      estado_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             dir_esq;
  logic [WIDTH-1:0] saida_q;
  logic             zero_q;
  logic             igual_q;
  logic             menor_q;
  logic             busy_q;
  logic             done_q;

  logic [SHAMT_W-1:0] shamt;
  logic               inicia;
  logic               eh_shift;
  logic               fim;
  logic [WIDTH-1:0]   res;
  logic [WIDTH-1:0]   acc_shift;
  logic [WIDTH-1:0]   fin_val;

  assign shamt     = bus.B[SHAMT_W-1:0];
  assign inicia    = bus.start && (estado_q == IDLE);
  assign eh_shift  = ((bus.OP == OP_SLL) || (bus.OP == OP_SRL)) && (shamt != '0);
  assign fim       = ((estado_q == SHIFT) || (estado_q == MUL)) && (cnt == '0);
  assign acc_shift = dir_esq ? (acc << 1) : (acc >> 1);

  // Single-cycle results; a zero shift amount degenerates to passing A.
  always_comb begin
    res = bus.A;
    case (bus.OP)
      OP_PASS: res = bus.A;
      OP_ADD:  res = bus.A + bus.B;
      OP_SUB:  res = bus.A - bus.B;
      OP_AND:  res = bus.A & bus.B;
      OP_XOR:  res = bus.A ^ bus.B;
      OP_SLL:  res = bus.A;
      OP_SRL:  res = bus.A;
      OP_MUL:  res = '0;
      default: res = bus.A;
    endcase
  end

`ifdef ULA_MUL_EN
  logic [WIDTH-1:0] mul_prox;

  ula_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (inicia && (bus.OP == OP_MUL)),
    .step   (estado_q == MUL),
    .a      (bus.A),
    .b      (bus.B),
    .result (mul_prox)
  );

  assign fin_val = (estado_q == MUL) ? mul_prox : acc_shift;
`else
  assign fin_val = acc_shift;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      dir_esq  <= 1'b0;
      saida_q  <= '0;
      zero_q   <= 1'b1;
      igual_q  <= 1'b0;
      menor_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          if (inicia) begin
            op_a <= bus.A;
            op_b <= bus.B;
            if (eh_shift) begin
              estado_q <= SHIFT;
              busy_q   <= 1'b1;
              acc      <= bus.A;
              cnt      <= CW'(shamt) - CW'(1);
              dir_esq  <= (bus.OP == OP_SLL);
            end
`ifdef ULA_MUL_EN
            else if (bus.OP == OP_MUL) begin
              estado_q <= MUL;
              busy_q   <= 1'b1;
              cnt      <= CW'(WIDTH - 1);
            end
`endif
            else begin
              saida_q <= res;
              zero_q  <= (res == '0);
              igual_q <= (bus.A == bus.B);
              menor_q <= ($signed(bus.A) < $signed(bus.B));
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT, MUL: begin
          acc <= acc_shift;
          if (fim) begin
            // Flags come from the operands captured at start, not the live inputs.
            estado_q <= IDLE;
            busy_q   <= 1'b0;
            saida_q  <= fin_val;
            zero_q   <= (fin_val == '0);
            igual_q  <= (op_a == op_b);
            menor_q  <= ($signed(op_a) < $signed(op_b));
            done_q   <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          estado_q <= IDLE;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign estado    = estado_q;
  assign bus.SAIDA = saida_q;
  assign bus.ZERO  = zero_q;
  assign bus.IGUAL = igual_q;
  assign bus.MENOR = menor_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed self-checking bench for ula_multiciclo; follows ULA_MUL_EN to pick
// the OP 111 expectations.
module tb_ula_multiciclo;
  import ula_pkg::*;

  localparam int W = 64;

  logic        clk = 1'b0;
  logic        reset;
  ula_estado_t estado;

  ula_multiciclo_if #(.WIDTH(W)) bus ();

  ula_multiciclo #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .estado (estado)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver: one-cycle start pulse; returns just after the accepting edge.
  task automatic go(input ula_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.OP    = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_single(input string tag, input ula_op_t op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] expv,
                            input logic ig, input logic me);
    logic [W-1:0] e;
    exp_q.push_back(expv);
    go(op, a, b);
    e = exp_q.pop_front();
    chk({tag, "_done"}, W'(bus.done), W'(1));
    chk({tag, "_busy"}, W'(bus.busy), W'(0));
    chk({tag, "_saida"}, bus.SAIDA, e);
    chk({tag, "_zero"}, W'(bus.ZERO), W'(e == '0));
    chk({tag, "_igual"}, W'(bus.IGUAL), W'(ig));
    chk({tag, "_menor"}, W'(bus.MENOR), W'(me));
    @(negedge clk);
    chk({tag, "_done_drop"}, W'(bus.done), W'(0));
    chk({tag, "_hold"}, bus.SAIDA, e);
  endtask

  task automatic run_multi(input string tag, input ula_op_t op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] expv, input int k,
                           input ula_estado_t st, input logic ig, input logic me,
                           input logic extra);
    logic [W-1:0] e;
    int lat;
    int busy_n;
    exp_q.push_back(expv);
    go(op, a, b);
    chk({tag, "_estado"}, W'(estado), W'(st));
    lat    = -1;
    busy_n = 0;
    for (int j = 0; j <= k + 10; j++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = j;
        bus.start = 1'b0;
        break;
      end
      if (extra) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.OP    = OP_PASS;
        bus.A     = {$urandom, $urandom};
        bus.B     = {$urandom, $urandom};
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    e = exp_q.pop_front();
    chk({tag, "_latency"}, W'(lat), W'(k));
    chk({tag, "_busy_cycles"}, W'(busy_n), W'(k));
    chk({tag, "_saida"}, bus.SAIDA, e);
    chk({tag, "_zero"}, W'(bus.ZERO), W'(e == '0));
    chk({tag, "_igual"}, W'(bus.IGUAL), W'(ig));
    chk({tag, "_menor"}, W'(bus.MENOR), W'(me));
    chk({tag, "_busy_end"}, W'(bus.busy), W'(0));
    @(negedge clk);
    chk({tag, "_done_drop"}, W'(bus.done), W'(0));
    chk({tag, "_hold"}, bus.SAIDA, e);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_saida"}, bus.SAIDA, '0);
    chk({tag, "_zero"}, W'(bus.ZERO), W'(1));
    chk({tag, "_igual"}, W'(bus.IGUAL), W'(0));
    chk({tag, "_menor"}, W'(bus.MENOR), W'(0));
    chk({tag, "_busy"}, W'(bus.busy), W'(0));
    chk({tag, "_done"}, W'(bus.done), W'(0));
    chk({tag, "_estado"}, W'(estado), W'(IDLE));
  endtask

  // Counts done pulses over a window where none may appear.
  task automatic no_done(input string tag, input int cycles);
    int n;
    n = 0;
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    chk({tag, "_no_done"}, W'(n), W'(0));
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.OP    = OP_PASS;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");

    run_single("add_wrap", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1);
    run_single("sub_neg", OP_SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    run_single("pass_eq", OP_PASS, 64'h1234, 64'h1234, 64'h1234, 1'b1, 1'b0);
    run_single("and", OP_AND, 64'hFF00_FF00_1234_5678, 64'h0F0F_0F0F_FFFF_0000,
               64'h0F00_0F00_1234_0000, 1'b0, 1'b1);
    run_single("xor_self", OP_XOR, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0);
    run_single("xor_mix", OP_XOR, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_single("sll_k0", OP_SLL, 64'hABCD, 64'd64, 64'hABCD, 1'b0, 1'b0);
    run_single("srl_k0", OP_SRL, 64'd3, 64'd0, 64'd3, 1'b0, 1'b0);

    run_multi("sll63", OP_SLL, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 63, SHIFT,
              1'b0, 1'b1, 1'b1);
    run_multi("srl4", OP_SRL, 64'h8000_0000_0000_0000, 64'h104, 64'h0800_0000_0000_0000, 4,
              SHIFT, 1'b0, 1'b1, 1'b0);
    run_multi("sll8", OP_SLL, 64'hF1, 64'd8, 64'hF100, 8, SHIFT, 1'b0, 1'b0, 1'b1);

    // Reset mid-shift, asserted together with a fresh start request.
    go(OP_SLL, 64'd1, 64'd20);
    repeat (5) @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.OP    = OP_ADD;
    bus.A     = 64'd9;
    bus.B     = 64'd9;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    chk_reset_state("rst_shift");
    no_done("rst_shift", 25);
    chk("rst_shift_saida_after", bus.SAIDA, '0);

`ifdef ULA_MUL_EN
    run_multi("mul", OP_MUL, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003, 64, MUL,
              1'b0, 1'b0, 1'b1);
    go(OP_MUL, 64'h1_0000_0001, 64'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_state("rst_mul");
    no_done("rst_mul", 70);
    chk("rst_mul_saida_after", bus.SAIDA, '0);
`else
    run_single("mul_off", OP_MUL, 64'd7, 64'd9, 64'd0, 1'b0, 1'b1);
    no_done("mul_off", 5);
    chk("mul_off_busy", W'(bus.busy), W'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
